bf16_exp_pwl_pipe: RTL and testbench
====================================

// Module: bf16_exp_pwl_pipe
//
// PURPOSE
//  Pipelined bfloat16 exp(x) approximator using a programmable piecewise-linear
//  table indexed by sign, exponent bin and top mantissa bits (sub-segments).
//  Successor to the fixed-table single-register exp unit. Adds runtime-loadable
//  coefficients, sub-segment resolution, valid/ready flow control and IEEE
//  special-value handling. Sits between activation buffers and the softmax
//  normaliser.
//
// PARAMETERS
//  EXP_LO    121  lowest biased exponent handled by the table
//  EXP_HI    133  highest biased exponent handled by the table
//  SUB_BITS  2    mantissa MSBs used as sub-segment index (0..6)
//  ADDR_W    8    tbl_addr width; must hold 2*(EXP_HI-EXP_LO+1)*2^SUB_BITS entries
//
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       async active-high reset
//  in_valid   in   1       data_i valid
//  in_ready   out  1       unit accepts data_i this cycle
//  data_i     in   16      bf16 operand x
//  out_valid  out  1       data_o valid
//  out_ready  in   1       downstream accepts data_o
//  data_o     out  16      bf16 exp(x)
//  flag_o     out  1       result came from special/clamp path, not table
//  tbl_we     in   1       coefficient write strobe
//  tbl_addr   in   ADDR_W  entry index
//  tbl_data   in   32      {base[31:16], slope[15:0]}, both unsigned
//
// BEHAVIOUR
//  - Reset: out_valid=0, data_o=0, flag_o=0. All stage valids and all table
//    entries clear to 0. in_ready=1 out of reset.
//  - Flow: en = !out_valid | out_ready; in_ready = en. All three stages advance
//    together on en. Accept on in_valid&in_ready. Latency 3 cycles; throughput
//    1/cycle. Bubbles propagate as invalid stages and are not collapsed.
//  - While out_valid & !out_ready: data_o/flag_o are held stable.
//  - S1 (capture/classify/read): s=x[15], e=x[14:7], m=x[6:0].
//    Special paths (flag=1):
//      e==255 & m!=0 -> 0x7FC0
//      +inf or (s=0, e>EXP_HI) -> 0x7F80
//      -inf or (s=1, e>EXP_HI) -> 0x0000
//      e<EXP_LO (incl. zero/denormal) -> 0x3F80
//    Otherwise:
//      addr = ((s*NBINS + e-EXP_LO) << SUB_BITS) + m[6:7-SUB_BITS],
//      NBINS = EXP_HI-EXP_LO+1;
//      frac = m[6-SUB_BITS:0] (width FW = 7-SUB_BITS).
//  - S2: prod = frac * slope (FW+16 bits); p = prod >> FW (16 bits).
//  - S3: r = s ? base - p : base + p, in 18-bit signed.
//    Clamp: r<0 -> 0x0000, flag=1; r>=0x7F80 -> 0x7F80, flag=1;
//    else data_o = r[15:0], flag=0.
//  - Table write: on tbl_we edge, entry[tbl_addr] <= tbl_data. Takes effect for
//    samples in S1 on the next cycle or later. In-flight samples keep the
//    coefficients already read. Write and lookup of the same address in the
//    same cycle: the lookup returns the old value. tbl_addr >= depth is ignored.
//  - Reset mid-operation: all in-flight samples are discarded and the table is
//    cleared. No output is produced for samples accepted before reset.
//
// TESTING
//  1. Reset, write entry 1 = {0x3F82, 0x0020}, SUB_BITS=2, in 0x3CB0
//     -> 3 cycles later data_o=0x3F92, flag_o=0.
//  2. Specials 0x7FC1, 0x7F80, 0xFF80, 0x4400, 0xC400, 0x0000
//     -> 0x7FC0, 0x7F80, 0x0000, 0x7F80, 0x0000, 0x3F80, all flag_o=1,
//     in order.
//  3. Stream 8 back-to-back valid inputs with out_ready low for 4 cycles
//     mid-stream -> no loss or duplication, in_ready low while stalled,
//     order preserved.
//  4. Entry with base 0x0010, slope 0xFFFF, s=1, frac max
//     -> data_o=0x0000, flag_o=1 (underflow clamp).
//  5. Write entry 1 the cycle after 0x3CB0 is accepted
//     -> that sample uses the old coefficients; the next 0x3CB0 uses the new.
//  6. Assert rst with 2 samples in flight
//     -> out_valid=0 immediately; table reads 0; no stale output after
//     release.

Source files
------------

// File: rtl/bf16_exp_pwl_pipe_if.sv
// Streaming and coefficient-load bundle for the bf16 exp(x) PWL pipeline.
// The master side drives operands and table writes; the slave side is the unit.
interface bf16_exp_pwl_pipe_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       data_i;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       data_o;
  logic              flag_o;
  logic              tbl_we;
  logic [ADDR_W-1:0] tbl_addr;
  logic [31:0]       tbl_data;

  modport master (
    output in_valid, data_i, out_ready, tbl_we, tbl_addr, tbl_data,
    input  in_ready, out_valid, data_o, flag_o
  );

  modport slave (
    input  in_valid, data_i, out_ready, tbl_we, tbl_addr, tbl_data,
    output in_ready, out_valid, data_o, flag_o
  );
endinterface

// File: rtl/bf16_exp_pwl_pipe.sv
// Three-stage bfloat16 exp(x) approximator: classify and table read, slope
// multiply, then base add/subtract with clamping. All stages advance on one enable.
module bf16_exp_pwl_pipe #(
  parameter int EXP_LO   = 121,
  parameter int EXP_HI   = 133,
  parameter int SUB_BITS = 2,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  bf16_exp_pwl_pipe_if.slave  bus
);

  localparam int NBINS = EXP_HI - EXP_LO + 1;
  localparam int DEPTH = 2 * NBINS * (1 << SUB_BITS);
  localparam int IW    = $clog2(DEPTH);
  localparam int FW    = 7 - SUB_BITS;

  typedef struct packed {
    logic          valid;
    logic          s;
    logic          spec;
    logic [15:0]   spec_val;
    logic [FW-1:0] frac;
    logic [15:0]   base;
    logic [15:0]   slope;
  } s1_t;

  typedef struct packed {
    logic        valid;
    logic        s;
    logic        spec;
    logic [15:0] spec_val;
    logic [15:0] base;
    logic [15:0] p;
  } s2_t;

  logic [31:0] tbl [DEPTH];
  s1_t         s1;
  s2_t         s2;
  logic        en;

  // A stalled output freezes the whole pipe, bubbles included.
  assign en          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // ---------------- S1: classify operand and read coefficients ----------------
  logic        in_s;
  logic [7:0]  in_e;
  logic [6:0]  in_m;
  logic        c_spec;
  logic [15:0] c_val;
  int          c_idx;
  logic [31:0] c_coef;

  assign in_s = bus.data_i[15];
  assign in_e = bus.data_i[14:7];
  assign in_m = bus.data_i[6:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise
    // a branch that skips an assignment infers a latch.
    c_spec = 1'b1;
    c_val  = 16'h0000;
    c_idx  = 0;
    if (in_e == 8'hFF && in_m != 7'd0) begin
      c_val = 16'h7FC0;
    end else if (in_e > 8'(EXP_HI)) begin
      c_val = in_s ? 16'h0000 : 16'h7F80;
    end else if (in_e < 8'(EXP_LO)) begin
      c_val = 16'h3F80;
    end else begin
      c_spec = 1'b0;
      c_idx  = (((in_s ? NBINS : 0) + (int'(in_e) - EXP_LO)) << SUB_BITS)
             + int'(in_m >> FW);
    end
  end

  // Combinational read before the write edge, so a same-cycle write is not seen.
  assign c_coef = (!c_spec && c_idx < DEPTH) ? tbl[IW'(c_idx)] : 32'd0;

  // ---------------- Coefficient table ----------------
  logic [ADDR_W-1:0] wr_addr;
  assign wr_addr = bus.tbl_addr;

  // NOTE: the table is deliberately reset so post-reset lookups are defined; this
  // forces it into flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= 32'd0;
    end else if (bus.tbl_we && int'(wr_addr) < DEPTH) begin
      tbl[IW'(wr_addr)] <= bus.tbl_data;
    end
  end

  // ---------------- S2 / S3 datapath ----------------
  logic [FW+15:0]     prod;
  logic [15:0]        p;
  logic signed [17:0] r;
  logic [15:0]        res_d;
  logic               res_f;

  assign prod = (FW+16)'(s1.frac) * (FW+16)'(s1.slope);
  assign p    = prod[FW+15:FW];

  always_comb begin
    r = s2.s ? ($signed({2'b00, s2.base}) - $signed({2'b00, s2.p}))
             : ($signed({2'b00, s2.base}) + $signed({2'b00, s2.p}));
    res_d = r[15:0];
    res_f = 1'b0;
    if (s2.spec) begin
      res_d = s2.spec_val;
      res_f = 1'b1;
    end else if (r < 18'sd0) begin
      res_d = 16'h0000;
      res_f = 1'b1;
    end else if (r >= 18'sh07F80) begin
      res_d = 16'h7F80;
      res_f = 1'b1;
    end
  end

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1            <= '0;
      s2            <= '0;
      bus.out_valid <= 1'b0;
      bus.data_o    <= 16'h0000;
      bus.flag_o    <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage read its predecessor's
      // old value on the same edge; blocking ones would collapse the pipe.
      s1.valid    <= bus.in_valid;
      s1.s        <= in_s;
      s1.spec     <= c_spec;
      s1.spec_val <= c_val;
      s1.frac     <= in_m[FW-1:0];
      s1.base     <= c_coef[31:16];
      s1.slope    <= c_coef[15:0];

      s2.valid    <= s1.valid;
      s2.s        <= s1.s;
      s2.spec     <= s1.spec;
      s2.spec_val <= s1.spec_val;
      s2.base     <= s1.base;
      s2.p        <= p;

      bus.out_valid <= s2.valid;
      bus.data_o    <= res_d;
      bus.flag_o    <= res_f;
    end
  end

endmodule

// File: tb/tb_bf16_exp_pwl_pipe.sv
// Directed bench for bf16_exp_pwl_pipe: table lookups, specials, clamps,
// back-pressure, coefficient write ordering and mid-flight reset.
module tb_bf16_exp_pwl_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bf16_exp_pwl_pipe_if #(.ADDR_W(8)) bus();

  bf16_exp_pwl_pipe #(
    .EXP_LO(121), .EXP_HI(133), .SUB_BITS(2), .ADDR_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] vin    [16];
  logic [15:0] vexp_d [16];
  logic        vexp_f [16];

  task automatic set_vec(input int i, input logic [15:0] x, input logic [15:0] d,
                         input logic f);
    vin[i]    = x;
    vexp_d[i] = d;
    vexp_f[i] = f;
  endtask

  task automatic write_tbl(input int addr, input logic [31:0] d);
    @(negedge clk);
    bus.tbl_we   = 1'b1;
    bus.tbl_addr = 8'(addr);
    bus.tbl_data = d;
    @(negedge clk);
    bus.tbl_we   = 1'b0;
  endtask

  // Single operand, checks latency, result and flag.
  task automatic send_one(input logic [15:0] x, input logic [15:0] ed, input logic ef,
                          input string nm);
    int lat;
    bit got;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.data_i    = x;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (bus.out_valid === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s timeout: out_valid never rose, required within 10 cycles", nm);
    end else begin
      n_vec += 2;
      if (lat !== 3) begin
        n_err++;
        $display("FAIL %s latency: got %0d required 3", nm, lat);
      end
      if (bus.data_o !== ed || bus.flag_o !== ef) begin
        n_err++;
        $display("FAIL %s data: got %h/%b required %h/%b", nm, bus.data_o, bus.flag_o, ed, ef);
      end
    end
  endtask

  // Streams vin[0..n-1] with out_ready dropped for stall_len cycles from stall_at.
  task automatic run_stream(input int n, input int stall_at, input int stall_len,
                            input string nm);
    int sent = 0;
    int rcvd = 0;
    int cyc  = 0;
    while (rcvd < n && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      bus.in_valid  = (sent < n);
      bus.data_i    = (sent < n) ? vin[sent] : 16'h0000;
      #1;
      n_vec++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        n_err++;
        $display("FAIL %s in_ready cyc %0d: got %b required %b", nm, cyc, bus.in_ready,
                 (!bus.out_valid || bus.out_ready));
      end
      if (bus.out_valid === 1'b1) begin
        n_vec++;
        if (rcvd >= n) begin
          n_err++;
          $display("FAIL %s extra output: got %h required none", nm, bus.data_o);
        end else if (bus.data_o !== vexp_d[rcvd] || bus.flag_o !== vexp_f[rcvd]) begin
          n_err++;
          $display("FAIL %s out[%0d]: got %h/%b required %h/%b", nm, rcvd, bus.data_o,
                   bus.flag_o, vexp_d[rcvd], vexp_f[rcvd]);
        end
        if (bus.out_ready) rcvd++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_vec++;
    if (rcvd !== n) begin
      n_err++;
      $display("FAIL %s count: got %0d outputs required %0d", nm, rcvd, n);
    end
    repeat (4) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s duplicate: got out_valid=%b required 0", nm, bus.out_valid);
      end
    end
  endtask

  // Collects n outputs (out_ready held high) against vexp_*.
  task automatic collect(input int n, input string nm);
    int rcvd = 0;
    for (int c = 0; c < 40 && rcvd < n; c++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        n_vec++;
        if (bus.data_o !== vexp_d[rcvd] || bus.flag_o !== vexp_f[rcvd]) begin
          n_err++;
          $display("FAIL %s out[%0d]: got %h/%b required %h/%b", nm, rcvd, bus.data_o,
                   bus.flag_o, vexp_d[rcvd], vexp_f[rcvd]);
        end
        rcvd++;
      end
    end
    n_vec++;
    if (rcvd !== n) begin
      n_err++;
      $display("FAIL %s count: got %0d outputs required %0d", nm, rcvd, n);
    end
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_i    = 16'h0000;
    bus.out_ready = 1'b1;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = 8'd0;
    bus.tbl_data  = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    n_vec += 4;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset out_valid: got %b required 0", bus.out_valid);
    end
    if (bus.data_o !== 16'h0000) begin
      n_err++; $display("FAIL reset data_o: got %h required 0000", bus.data_o);
    end
    if (bus.flag_o !== 1'b0) begin
      n_err++; $display("FAIL reset flag_o: got %b required 0", bus.flag_o);
    end
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset in_ready: got %b required 1", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lookup;
    write_tbl(1, {16'h3F82, 16'h0020});
    write_tbl(4, {16'h3F00, 16'h0100});
    write_tbl(2, {16'h7F90, 16'h0000});
    write_tbl(3, {16'h7F7F, 16'h0000});
    send_one(16'h3CB0, 16'h3F92, 1'b0, "lookup_e121_sub1");
    send_one(16'h3D05, 16'h3F28, 1'b0, "lookup_e122_sub0");
    send_one(16'h3CC0, 16'h7F80, 1'b1, "overflow_clamp");
    send_one(16'h3CE0, 16'h7F7F, 1'b0, "below_clamp_edge");
  endtask

  task automatic test_specials;
    set_vec(0, 16'h7FC1, 16'h7FC0, 1'b1);
    set_vec(1, 16'h7F80, 16'h7F80, 1'b1);
    set_vec(2, 16'hFF80, 16'h0000, 1'b1);
    set_vec(3, 16'h4400, 16'h7F80, 1'b1);
    set_vec(4, 16'hC400, 16'h0000, 1'b1);
    set_vec(5, 16'h0000, 16'h3F80, 1'b1);
    set_vec(6, 16'h4300, 16'h7F80, 1'b1);
    set_vec(7, 16'h3C00, 16'h3F80, 1'b1);
    set_vec(8, 16'h4280, 16'h0000, 1'b0);
    run_stream(9, 0, 0, "specials");
  endtask

  task automatic test_back_to_back;
    set_vec(0, 16'h3CB0, 16'h3F92, 1'b0);
    set_vec(1, 16'h3D05, 16'h3F28, 1'b0);
    set_vec(2, 16'h7FC1, 16'h7FC0, 1'b1);
    set_vec(3, 16'h3CC0, 16'h7F80, 1'b1);
    set_vec(4, 16'h3CE0, 16'h7F7F, 1'b0);
    set_vec(5, 16'h0000, 16'h3F80, 1'b1);
    set_vec(6, 16'hC400, 16'h0000, 1'b1);
    set_vec(7, 16'h4280, 16'h0000, 1'b0);
    run_stream(8, 4, 4, "stall_stream");
  endtask

  task automatic test_underflow;
    write_tbl(55, {16'h0010, 16'hFFFF});
    send_one(16'hBCFF, 16'h0000, 1'b1, "underflow_clamp");
  endtask

  task automatic test_write_hazard;
    set_vec(0, 16'h3CB0, 16'h3F92, 1'b0);
    set_vec(1, 16'h3CB0, 16'h3F20, 1'b0);
    set_vec(2, 16'h3CB0, 16'h3F20, 1'b0);
    set_vec(3, 16'h3CB0, 16'h3E00, 1'b0);
    bus.out_ready = 1'b1;
    fork
      begin
        @(negedge clk);
        bus.in_valid = 1'b1; bus.data_i = 16'h3CB0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.tbl_we = 1'b1; bus.tbl_addr = 8'd1; bus.tbl_data = {16'h3F00, 16'h0040};
        @(negedge clk);
        bus.tbl_we = 1'b0;
        bus.in_valid = 1'b1; bus.data_i = 16'h3CB0;
        @(negedge clk);
        bus.tbl_we = 1'b1; bus.tbl_addr = 8'd1; bus.tbl_data = {16'h3E00, 16'h0000};
        @(negedge clk);
        bus.tbl_we = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      collect(4, "write_hazard");
    join
  endtask

  task automatic test_reset_midflight;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.data_i = 16'h3CB0;
    @(negedge clk);
    bus.data_i = 16'h3D05;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL pre_reset out_valid: got %b required 1", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    n_vec += 2;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL async_reset out_valid: got %b required 0", bus.out_valid);
    end
    if (bus.data_o !== 16'h0000 || bus.flag_o !== 1'b0) begin
      n_err++; $display("FAIL async_reset data: got %h/%b required 0000/0", bus.data_o, bus.flag_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
        n_err++; $display("FAIL stale_output cyc %0d: got out_valid=%b required 0", c, bus.out_valid);
      end
    end
    send_one(16'h3CB0, 16'h0000, 1'b0, "cleared_entry1");
    send_one(16'h3D05, 16'h0000, 1'b0, "cleared_entry4");
  endtask

  initial begin
    test_reset;
    test_lookup;
    test_specials;
    test_back_to_back;
    test_underflow;
    test_write_hazard;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
